// File: rtl/sram_valrdy_adapter.sv
// sram_valrdy_adapter: val/rdy request/response front-end for a
// single-port SRAM macro with active-low pins and one-cycle read latency.
//
// Ports
//   clk_i, reset_i       clock, synchronous active-high reset
//   req_*_i / req_rdy_o  request stream (type 0 = read, 1 = write)
//   resp_*_o / resp_rdy_i response stream, in request order
//   sram_*_o             macro pins (CSB/WEB/OEB/A/I/WBM)
//   sram_rdata_i         macro read data, valid the cycle after a read
module sram_valrdy_adapter #(
   parameter int p_data_nbits  = 128,
   parameter int p_num_entries = 256,
   parameter int p_addr_nbits  = $clog2(p_num_entries),
   parameter int p_mask_nbits  = p_data_nbits / 8,
   parameter int p_resp_depth  = 3
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    req_val_i,
   output logic                    req_rdy_o,
   input  logic                    req_type_i,
   input  logic [p_addr_nbits-1:0] req_addr_i,
   input  logic [p_data_nbits-1:0] req_data_i,
   input  logic [p_mask_nbits-1:0] req_wmask_i,
   output logic                    resp_val_o,
   input  logic                    resp_rdy_i,
   output logic                    resp_type_o,
   output logic [p_data_nbits-1:0] resp_data_o,
   output logic                    sram_csb_o,
   output logic                    sram_web_o,
   output logic                    sram_oeb_o,
   output logic [p_addr_nbits-1:0] sram_addr_o,
   output logic [p_data_nbits-1:0] sram_wdata_o,
   output logic [p_mask_nbits-1:0] sram_wbm_o,
   input  logic [p_data_nbits-1:0] sram_rdata_i
);

   localparam int PTR_W = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
   localparam int CNT_W = $clog2(p_resp_depth + 1);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(p_resp_depth - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(p_resp_depth);
   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(p_resp_depth);

   logic                    inf_val_q, inf_val_d;
   logic                    inf_type_q, inf_type_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic                    q_type_q [p_resp_depth];
   logic [p_data_nbits-1:0] q_data_q [p_resp_depth];

   logic            accept;
   logic            enq;
   logic            deq;
   logic [CNT_W:0]  occ;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Slots already committed: queued entries plus the one in flight.
   // Reserving a slot for the in-flight read means the macro's
   // fixed-latency data never needs to be stalled.
   assign occ       = {1'b0, count_q} + (CNT_W + 1)'(inf_val_q);
   assign req_rdy_o = !reset_i && (occ < DEPTH_C);

   assign accept = req_val_i & req_rdy_o;
   assign enq    = inf_val_q;
   assign deq    = resp_val_o & resp_rdy_i;

   assign sram_csb_o   = ~accept;
   assign sram_web_o   = ~(accept & req_type_i);
   assign sram_oeb_o   = 1'b0;
   assign sram_addr_o  = accept ? req_addr_i : '0;
   assign sram_wdata_o = accept ? req_data_i : '0;
   assign sram_wbm_o   = (accept & req_type_i) ? req_wmask_i : '0;

   assign resp_val_o  = !reset_i && (count_q != '0);
   assign resp_type_o = q_type_q[rd_ptr_q];
   assign resp_data_o = q_data_q[rd_ptr_q];

   always_comb begin
      inf_val_d  = accept;
      inf_type_d = accept & req_type_i;
      wr_ptr_d   = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d    = count_q;
      unique case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         inf_val_q  <= 1'b0;
         inf_type_q <= 1'b0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         inf_val_q  <= inf_val_d;
         inf_type_q <= inf_type_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Payload storage carries no reset; validity lives in count_q.
   always_ff @(posedge clk_i) begin
      if (enq && !reset_i) begin
         q_type_q[wr_ptr_q] <= inf_type_q;
         q_data_q[wr_ptr_q] <= inf_type_q ? '0 : sram_rdata_i;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(enq && (count_q == FULL_CNT)))
         else $error("sram_valrdy_adapter: response queue overflow");
      end
   end
`endif

endmodule
